// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared constants for the add/subtract arithmetic family
package arith_pkg;

    localparam int DEFAULT_WIDTH = 16;

    // Bit positions used by consumers that pack the result flags into one vector.
    localparam int FLAG_BOUT = 0;
    localparam int FLAG_OVF  = 1;
    localparam int FLAG_ZERO = 2;
    localparam int FLAG_NEG  = 3;

endpackage

// File: rtl/cond_sum_half.sv
// rtl/cond_sum_half.sv - conditional-sum block: x + y for both carry-in values
module cond_sum_half #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] sum0,
    output logic         carry0,
    output logic [W-1:0] sum1,
    output logic         carry1
);

    logic [W:0] full0;
    logic [W:0] full1;

    assign full0  = {1'b0, x} + {1'b0, y};
    assign full1  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, 1'b1};
    assign sum0   = full0[W-1:0];
    assign carry0 = full0[W];
    assign sum1   = full1[W-1:0];
    assign carry1 = full1[W];

endmodule

// File: rtl/csla_sub_pipe.sv
// rtl/csla_sub_pipe.sv - two-stage carry-select subtractor (a - b - bin) with valid/ready
module csla_sub_pipe
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int LO_W = WIDTH / 2;
    localparam int HI_W = WIDTH - LO_W;

    // Subtraction as a + ~b + ~bin; the low half takes the inverted borrow as carry-in.
    logic [LO_W:0]   lo_full;
    logic [HI_W-1:0] hi_sum0, hi_sum1;
    logic            hi_carry0, hi_carry1;

    assign lo_full = {1'b0, a[LO_W-1:0]} + {1'b0, ~b[LO_W-1:0]} + {{LO_W{1'b0}}, ~bin};

    cond_sum_half #(.W(HI_W)) u_hi (
        .x      (a[WIDTH-1:LO_W]),
        .y      (~b[WIDTH-1:LO_W]),
        .sum0   (hi_sum0),
        .carry0 (hi_carry0),
        .sum1   (hi_sum1),
        .carry1 (hi_carry1)
    );

    logic            s1_valid;
    logic [LO_W-1:0] s1_lo_sum;
    logic            s1_lo_carry;
    logic [HI_W-1:0] s1_hi_c0, s1_hi_c1;
    logic            s1_carry_c0, s1_carry_c1;
    logic            s1_a_msb, s1_b_msb;

    logic s2_free, advance, in_fire;

    assign s2_free  = !out_valid || out_ready;
    assign advance  = s1_valid && s2_free;
    assign in_ready = !rst && (!s1_valid || s2_free);
    assign in_fire  = in_valid && in_ready;

    logic [HI_W-1:0]  hi_sel;
    logic             carry_sel;
    logic [WIDTH-1:0] diff_next;

    assign hi_sel    = s1_lo_carry ? s1_hi_c1 : s1_hi_c0;
    assign carry_sel = s1_lo_carry ? s1_carry_c1 : s1_carry_c0;
    assign diff_next = {hi_sel, s1_lo_sum};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_lo_sum   <= '0;
            s1_lo_carry <= 1'b0;
            s1_hi_c0    <= '0;
            s1_hi_c1    <= '0;
            s1_carry_c0 <= 1'b0;
            s1_carry_c1 <= 1'b0;
            s1_a_msb    <= 1'b0;
            s1_b_msb    <= 1'b0;
            out_valid   <= 1'b0;
            diff        <= '0;
            bout        <= 1'b0;
            ovf         <= 1'b0;
            zero        <= 1'b0;
            neg         <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_valid    <= 1'b1;
                s1_lo_sum   <= lo_full[LO_W-1:0];
                s1_lo_carry <= lo_full[LO_W];
                s1_hi_c0    <= hi_sum0;
                s1_hi_c1    <= hi_sum1;
                s1_carry_c0 <= hi_carry0;
                s1_carry_c1 <= hi_carry1;
                s1_a_msb    <= a[WIDTH-1];
                s1_b_msb    <= b[WIDTH-1];
            end else if (advance) begin
                s1_valid <= 1'b0;
            end

            // Output registers only load on advance, so a stalled result holds steady.
            if (advance) begin
                out_valid <= 1'b1;
                diff      <= diff_next;
                bout      <= ~carry_sel;
                ovf       <= (s1_a_msb != s1_b_msb) && (diff_next[WIDTH-1] != s1_a_msb);
                zero      <= (diff_next == '0);
                neg       <= diff_next[WIDTH-1];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_csla_sub_pipe.sv
// tb/tb_csla_sub_pipe.sv - directed self-checking bench for csla_sub_pipe
module tb_csla_sub_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout, ovf, zero, neg;

    int total = 0;
    int bad   = 0;

    csla_sub_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero),
        .neg       (neg)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    // One beat into an empty pipe with out_ready=1; checks two-cycle latency and all outputs.
    task automatic run_vec(input string tag, input logic [15:0] va, input logic [15:0] vb,
                           input logic vbin, input logic [15:0] xd, input logic xbout,
                           input logic xovf, input logic xzero, input logic xneg);
        @(negedge clk);
        a = va; b = vb; bin = vbin; in_valid = 1'b1;
        #1 expect_eq({tag, ".in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        expect_eq({tag, ".early_valid"}, out_valid, 0);
        @(negedge clk);
        expect_eq({tag, ".out_valid"}, out_valid, 1);
        expect_eq({tag, ".diff"}, diff, xd);
        expect_eq({tag, ".bout"}, bout, xbout);
        expect_eq({tag, ".ovf"}, ovf, xovf);
        expect_eq({tag, ".zero"}, zero, xzero);
        expect_eq({tag, ".neg"}, neg, xneg);
    endtask

    logic [15:0] bp_a [4] = '{16'h1234, 16'h0100, 16'h0000, 16'h5555};
    logic [15:0] bp_b [4] = '{16'h0234, 16'h0001, 16'h0001, 16'h5554};
    logic        bp_c [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] bp_d [4] = '{16'h1000, 16'h00FF, 16'hFFFF, 16'h0000};
    logic        bp_o [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int idx, oidx;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
        #12;
        expect_eq("rst.out_valid", out_valid, 0);
        expect_eq("rst.in_ready", in_ready, 0);
        expect_eq("rst.diff", diff, 0);
        @(negedge clk);
        rst = 1'b0;

        run_vec("basic",   16'h1234, 16'h0234, 1'b0, 16'h1000, 0, 0, 0, 0);
        run_vec("under",   16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1, 0, 0, 1);
        run_vec("halfbnd", 16'h0100, 16'h0001, 1'b0, 16'h00FF, 0, 0, 0, 0);
        run_vec("zerobin", 16'h5555, 16'h5554, 1'b1, 16'h0000, 0, 0, 1, 0);
        run_vec("ovfneg",  16'h8000, 16'h0001, 1'b0, 16'h7FFF, 0, 1, 0, 0);
        run_vec("ovfpos",  16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1, 1, 0, 1);

        // Backpressure: out_ready low for cycles 0..4, then high.
        @(negedge clk);
        idx = 0; oidx = 0;
        for (int cyc = 0; cyc < 11; cyc++) begin
            out_ready = (cyc >= 5);
            in_valid  = (idx < 4);
            if (idx < 4) begin
                a = bp_a[idx]; b = bp_b[idx]; bin = bp_c[idx];
            end
            #1;
            if (cyc == 4) begin
                expect_eq("bp.accepted", idx, 2);
                expect_eq("bp.in_ready_full", in_ready, 0);
                expect_eq("bp.hold_diff", diff, bp_d[0]);
            end
            if (cyc >= 5 && cyc <= 8)
                expect_eq($sformatf("bp.no_bubble%0d", cyc), out_valid, 1);
            if (out_valid && out_ready && oidx < 4) begin
                expect_eq($sformatf("bp.diff%0d", oidx), diff, bp_d[oidx]);
                expect_eq($sformatf("bp.bout%0d", oidx), bout, bp_o[oidx]);
                oidx++;
            end
            if (in_valid && in_ready) idx++;
            @(negedge clk);
        end
        expect_eq("bp.emitted", oidx, 4);
        expect_eq("bp.drained", out_valid, 0);

        // Reset mid-flight: fill both stages, then assert rst between edges.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; a = 16'h4000 + 16'(i); b = 16'h0001; bin = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        expect_eq("mid.full_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        expect_eq("mid.out_valid", out_valid, 0);
        expect_eq("mid.diff", diff, 0);
        expect_eq("mid.in_ready", in_ready, 0);
        @(negedge clk);
        expect_eq("mid.held_in_ready", in_ready, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        #1 expect_eq("mid.post_in_ready", in_ready, 1);
        @(negedge clk);
        expect_eq("mid.no_stale", out_valid, 0);
        run_vec("postrst", 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
